// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the writeback handshakes, the scoreboard set port and the register
//   file write port used by regfile_wb_arbiter.
//   Parameters: DATA_WIDTH (write data width), ADDR_WIDTH (register address width).
//   Modports:
//     slave  - the arbiter: takes requests, hold and sb_set; drives the readys,
//              the rf_* write port and busy.
//     master - the requester/issue side: the mirror image of slave.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  hold;
  logic                  sb_set;
  logic [ADDR_WIDTH-1:0] sb_set_addr;
  logic                  rf_write;
  logic [ADDR_WIDTH-1:0] rf_wrAddr;
  logic [DATA_WIDTH-1:0] rf_wrData;
  logic [NUM_REGS-1:0]   busy;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  hold, sb_set, sb_set_addr,
    output a_ready, b_ready, rf_write, rf_wrAddr, rf_wrData, busy
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output hold, sb_set, sb_set_addr,
    input  a_ready, b_ready, rf_write, rf_wrAddr, rf_wrData, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter sharing the single register file write port between
//   writeback requester A (ALU) and B (memory load). The granted write is
//   registered and appears on rf_* one cycle after the handshake. A pending-
//   write scoreboard (busy) is set by the issue stage and cleared by writeback.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high reset
//     bus   - regfile_wb_arbiter_if.slave (requests, readys, hold, sb_set,
//             rf_write/rf_wrAddr/rf_wrData, busy)
//   Optional feature macro: REGFILE_XZR_DROP_EN
//     When defined, register NUM_REGS-1 (zero register) is never written:
//     transfers to it still handshake and rotate priority, but rf_write stays
//     low, and busy for it is held at 0.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Priority state: which requester won the most recent transfer.
  localparam logic [0:0] GRANT_A = 1'b0;
  localparam logic [0:0] GRANT_B = 1'b1;

  logic [0:0]            lastGrant;
  logic                  grantA;
  logic                  grantB;
  logic                  xfer;
  logic                  dropWrite;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;
  logic                  rfWriteReg;
  logic [ADDR_WIDTH-1:0] rfAddrReg;
  logic [DATA_WIDTH-1:0] rfDataReg;
  logic [NUM_REGS-1:0]   busyReg;
  logic [NUM_REGS-1:0]   busyNext;

  // A requester wins if it is alone, or if both are valid and the other one
  // won last time. hold masks both, so at most one grant is ever high.
  assign grantA = !bus.hold && bus.a_valid && (!bus.b_valid || lastGrant == GRANT_B);
  assign grantB = !bus.hold && bus.b_valid && (!bus.a_valid || lastGrant == GRANT_A);
  assign xfer   = grantA || grantB;

  assign selAddr = grantA ? bus.a_addr : bus.b_addr;
  assign selData = grantA ? bus.a_data : bus.b_data;

`ifdef REGFILE_XZR_DROP_EN
  localparam logic [ADDR_WIDTH-1:0] XZR_ADDR = '1;
  assign dropWrite = (selAddr == XZR_ADDR);
`else
  assign dropWrite = 1'b0;
`endif

  // Clear on writeback first, then apply the issue-side set so that a younger
  // producer marking the same register on the same edge keeps it busy.
  always_comb begin
    busyNext = busyReg;
    if (xfer) begin
      busyNext[selAddr] = 1'b0;
    end
    if (bus.sb_set) begin
      busyNext[bus.sb_set_addr] = 1'b1;
    end
`ifdef REGFILE_XZR_DROP_EN
    busyNext[NUM_REGS-1] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant  <= GRANT_B;
      rfWriteReg <= 1'b0;
      rfAddrReg  <= '0;
      rfDataReg  <= '0;
      busyReg    <= '0;
    end else begin
      busyReg    <= busyNext;
      rfWriteReg <= xfer && !dropWrite;
      if (xfer) begin
        lastGrant <= grantB ? GRANT_B : GRANT_A;
      end
      // Dropped zero-register writes leave the write port values untouched.
      if (xfer && !dropWrite) begin
        rfAddrReg <= selAddr;
        rfDataReg <= selData;
      end
    end
  end

  assign bus.a_ready   = grantA;
  assign bus.b_ready   = grantB;
  assign bus.rf_write  = rfWriteReg;
  assign bus.rf_wrAddr = rfAddrReg;
  assign bus.rf_wrData = rfDataReg;
  assign bus.busy      = busyReg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  regfile_wb_arbiter_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

  regfile_wb_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge; registered outputs from the
  // preceding rising edge are checked at that same falling edge.
  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.hold = 1'b0; bus.sb_set = 1'b0; bus.sb_set_addr = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL reset_rf_write: got %b want 0", bus.rf_write); end
    total++; if (bus.rf_wrAddr !== 5'd0) begin bad++; $display("FAIL reset_rf_wrAddr: got %0d want 0", bus.rf_wrAddr); end
    total++; if (bus.rf_wrData !== 64'd0) begin bad++; $display("FAIL reset_rf_wrData: got %h want 0", bus.rf_wrData); end
    total++; if (bus.busy !== 32'd0) begin bad++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_single_write();
    pulse_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 64'h1234;
    #1;
    total++; if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL single_a_ready: got %b want 1", bus.a_ready); end
    total++; if (bus.b_ready !== 1'b0) begin bad++; $display("FAIL single_b_ready: got %b want 0", bus.b_ready); end
    @(negedge clk);
    total++; if (bus.rf_write !== 1'b1) begin bad++; $display("FAIL single_rf_write: got %b want 1", bus.rf_write); end
    total++; if (bus.rf_wrAddr !== 5'd5) begin bad++; $display("FAIL single_rf_wrAddr: got %0d want 5", bus.rf_wrAddr); end
    total++; if (bus.rf_wrData !== 64'h1234) begin bad++; $display("FAIL single_rf_wrData: got %h want 1234", bus.rf_wrData); end
    idle_inputs();
    @(negedge clk);
    total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL single_rf_write_drop: got %b want 0", bus.rf_write); end
    total++; if (bus.rf_wrAddr !== 5'd5) begin bad++; $display("FAIL single_addr_hold: got %0d want 5", bus.rf_wrAddr); end
    $display("test_single_write: addr=5 data=1234");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  expAddr [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    logic [63:0] expData [4] = '{64'hAAAA, 64'hBBBB, 64'hAAAA, 64'hBBBB};
    pulse_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 64'hAAAA;
    bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 64'hBBBB;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (bus.a_ready !== (k % 2 == 0)) begin bad++; $display("FAIL rr_a_ready[%0d]: got %b want %b", k, bus.a_ready, (k % 2 == 0)); end
      total++; if (bus.b_ready !== (k % 2 == 1)) begin bad++; $display("FAIL rr_b_ready[%0d]: got %b want %b", k, bus.b_ready, (k % 2 == 1)); end
      @(negedge clk);
      if (k == 3) idle_inputs();
      total++; if (bus.rf_write !== 1'b1) begin bad++; $display("FAIL rr_rf_write[%0d]: got %b want 1", k, bus.rf_write); end
      total++; if (bus.rf_wrAddr !== expAddr[k]) begin bad++; $display("FAIL rr_rf_wrAddr[%0d]: got %0d want %0d", k, bus.rf_wrAddr, expAddr[k]); end
      total++; if (bus.rf_wrData !== expData[k]) begin bad++; $display("FAIL rr_rf_wrData[%0d]: got %h want %h", k, bus.rf_wrData, expData[k]); end
      $display("test_back_to_back: grant %0d addr=%0d", k, expAddr[k]);
    end
  endtask

  task automatic test_scoreboard();
    pulse_reset();
    bus.sb_set = 1'b1; bus.sb_set_addr = 5'd7;
    @(negedge clk);
    total++; if (bus.busy !== 32'h0000_0080) begin bad++; $display("FAIL sb_set7: got %h want 00000080", bus.busy); end
    bus.sb_set = 1'b0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 64'h77;
    #1;
    total++; if (bus.b_ready !== 1'b1) begin bad++; $display("FAIL sb_b_ready: got %b want 1", bus.b_ready); end
    @(negedge clk);
    idle_inputs();
    total++; if (bus.rf_write !== 1'b1) begin bad++; $display("FAIL sb_rf_write: got %b want 1", bus.rf_write); end
    total++; if (bus.rf_wrAddr !== 5'd7) begin bad++; $display("FAIL sb_rf_wrAddr: got %0d want 7", bus.rf_wrAddr); end
    total++; if (bus.busy !== 32'd0) begin bad++; $display("FAIL sb_clear7: got %h want 0", bus.busy); end
    $display("test_scoreboard: set/clear reg 7");
  endtask

  task automatic test_same_edge();
    pulse_reset();
    // Also mark reg 4 so set and clear of different bits are seen together.
    bus.sb_set = 1'b1; bus.sb_set_addr = 5'd4;
    @(negedge clk);
    bus.sb_set = 1'b1; bus.sb_set_addr = 5'd9;
    bus.a_valid = 1'b1; bus.a_addr = 5'd9; bus.a_data = 64'h99;
    @(negedge clk);
    total++; if (bus.busy !== 32'h0000_0210) begin bad++; $display("FAIL same9_busy: got %h want 00000210", bus.busy); end
    total++; if (bus.rf_write !== 1'b1 || bus.rf_wrAddr !== 5'd9) begin bad++; $display("FAIL same9_write: got %b/%0d want 1/9", bus.rf_write, bus.rf_wrAddr); end
    bus.sb_set = 1'b1; bus.sb_set_addr = 5'd12;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 64'h44;
    @(negedge clk);
    idle_inputs();
    total++; if (bus.busy !== 32'h0000_1200) begin bad++; $display("FAIL diff_bits_busy: got %h want 00001200", bus.busy); end
    $display("test_same_edge: reg 9 kept busy, reg 4 cleared, reg 12 set");
  endtask

  task automatic test_hold();
    pulse_reset();
    bus.hold = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 64'h3;
    bus.b_valid = 1'b1; bus.b_addr = 5'd6; bus.b_data = 64'h6;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin bad++; $display("FAIL hold_ready[%0d]: got %b%b want 00", k, bus.a_ready, bus.b_ready); end
      @(negedge clk);
      total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL hold_rf_write[%0d]: got %b want 0", k, bus.rf_write); end
    end
    bus.hold = 1'b0;
    #1;
    total++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin bad++; $display("FAIL hold_release_A: got %b%b want 10", bus.a_ready, bus.b_ready); end
    @(negedge clk);
    #1;
    total++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin bad++; $display("FAIL hold_then_B: got %b%b want 01", bus.a_ready, bus.b_ready); end
    @(negedge clk);
    idle_inputs();
    $display("test_hold: 3 held cycles then A,B");
  endtask

  task automatic test_async_reset();
    logic [31:0] expBusy;
`ifdef REGFILE_XZR_DROP_EN
    expBusy = 32'h7FFF_FFFF;
`else
    expBusy = 32'hFFFF_FFFF;
`endif
    pulse_reset();
    for (int i = 31; i >= 0; i--) begin
      bus.sb_set = 1'b1; bus.sb_set_addr = 5'(i);
      if (i == 0) begin
        bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 64'hDEAD;
      end
      @(negedge clk);
    end
    idle_inputs();
    total++; if (bus.rf_write !== 1'b1) begin bad++; $display("FAIL pre_reset_rf_write: got %b want 1", bus.rf_write); end
    total++; if (bus.busy !== expBusy) begin bad++; $display("FAIL pre_reset_busy: got %h want %h", bus.busy, expBusy); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL async_rf_write: got %b want 0", bus.rf_write); end
    total++; if (bus.busy !== 32'd0) begin bad++; $display("FAIL async_busy: got %h want 0", bus.busy); end
    total++; if (bus.rf_wrData !== 64'd0) begin bad++; $display("FAIL async_rf_wrData: got %h want 0", bus.rf_wrData); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL post_reset_rf_write: got %b want 0", bus.rf_write); end
    $display("test_async_reset: outputs cleared without clock edge");
  endtask

  task automatic test_reg31();
    pulse_reset();
    bus.sb_set = 1'b1; bus.sb_set_addr = 5'd31;
    bus.a_valid = 1'b1; bus.a_addr = 5'd31; bus.a_data = 64'h3131;
    #1;
    total++; if (bus.a_ready !== 1'b1) begin bad++; $display("FAIL r31_a_ready: got %b want 1", bus.a_ready); end
    @(negedge clk);
    bus.sb_set = 1'b0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd8; bus.b_data = 64'h88;
    // A just won, so B must win the contention now.
    #1;
    total++; if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin bad++; $display("FAIL r31_next_B: got %b%b want 01", bus.a_ready, bus.b_ready); end
`ifdef REGFILE_XZR_DROP_EN
    total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL xzr_rf_write: got %b want 0", bus.rf_write); end
    total++; if (bus.busy[31] !== 1'b0) begin bad++; $display("FAIL xzr_busy31: got %b want 0", bus.busy[31]); end
`else
    total++; if (bus.rf_write !== 1'b1 || bus.rf_wrAddr !== 5'd31) begin bad++; $display("FAIL r31_write: got %b/%0d want 1/31", bus.rf_write, bus.rf_wrAddr); end
    total++; if (bus.busy[31] !== 1'b1) begin bad++; $display("FAIL r31_busy31: got %b want 1", bus.busy[31]); end
`endif
    @(negedge clk);
    idle_inputs();
    total++; if (bus.rf_write !== 1'b1 || bus.rf_wrAddr !== 5'd8) begin bad++; $display("FAIL r31_then_b8: got %b/%0d want 1/8", bus.rf_write, bus.rf_wrAddr); end
    $display("test_reg31: addr 31 transfer then B addr 8");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_scoreboard();
    test_same_edge();
    test_hold();
    test_async_reset();
    test_reg31();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
